// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage register pipeline with a valid bit per stage.
// Supports stall, synchronous preset to a fixed pattern, a run-time output tap
// and an occupancy count. It is used to delay data and flags so that they line
// up with the ECC encode/decode latency.
module dff_pipe #(
    parameter int unsigned         WIDTH      = 8,
    parameter int unsigned         DEPTH      = 4,
    parameter logic [WIDTH-1:0]    PRESET_VAL = {WIDTH{1'b1}},
    localparam int unsigned        SELW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             preset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d,
    input  logic [SELW-1:0]  dly,
    output logic [WIDTH-1:0] q,
    output logic             out_valid,
    output logic [SELW-1:0]  occ
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [SELW-1:0]  occ_q;
    logic [SELW-1:0]  occ_d;
    logic [SELW-1:0]  tap;

    // Next state: preset wins over advance; otherwise everything holds.
    always_comb begin
        stage_d = stage_q;
        v_d     = v_q;
        occ_d   = occ_q;
        if (preset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_d[i] = PRESET_VAL;
            end
            v_d   = '0;
            occ_d = '0;
        end else if (en) begin
            stage_d[0] = d;
            v_d[0]     = in_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
                v_d[i]     = v_q[i-1];
            end
            // Only a one-sided change moves the count; in and out together cancel.
            if (in_valid && !v_q[DEPTH-1]) begin
                occ_d = occ_q + 1'b1;
            end else if (!in_valid && v_q[DEPTH-1]) begin
                occ_d = occ_q - 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            v_q   <= '0;
            occ_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            v_q   <= v_d;
            occ_q <= occ_d;
        end
    end

    // Clamp the requested delay into the legal range 1..DEPTH.
    always_comb begin
        tap = dly;
        if (dly == '0) begin
            tap = SELW'(1);
        end else if (dly > SELW'(DEPTH)) begin
            tap = SELW'(DEPTH);
        end
    end

    // Output mux straight off the stage registers; no extra latency.
    always_comb begin
        q         = stage_q[0];
        out_valid = v_q[0];
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (tap == SELW'(i + 1)) begin
                q         = stage_q[i];
                out_valid = v_q[i];
            end
        end
    end

    assign occ = occ_q;

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed bench for dff_pipe (WIDTH=8, DEPTH=4, PRESET_VAL=8'hA5).
// A small stage model predicts q/out_valid/occ every cycle; a scoreboard queue
// checks that valid samples emerge in order with no loss or duplication.
module tb_dff_pipe;

    logic       clk;
    logic       reset;
    logic       preset;
    logic       en;
    logic       in_valid;
    logic [7:0] d;
    logic [2:0] dly;
    logic [7:0] q;
    logic       out_valid;
    logic [2:0] occ;

    int total;
    int bad;

    logic [7:0] md [4];
    logic       mv [4];
    logic       adv_last;
    logic [7:0] sb [$];

    dff_pipe #(
        .WIDTH      (8),
        .DEPTH      (4),
        .PRESET_VAL (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .preset    (preset),
        .en        (en),
        .in_valid  (in_valid),
        .d         (d),
        .dly       (dly),
        .q         (q),
        .out_valid (out_valid),
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int tap_of(input logic [2:0] s);
        int t;
        t = int'(s);
        if (t == 0) t = 1;
        if (t > 4) t = 4;
        return t;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            md[i] = 8'h00;
            mv[i] = 1'b0;
        end
        sb.delete();
        adv_last = 1'b0;
    endtask

    task automatic model_edge(input logic p, input logic e, input logic iv, input logic [7:0] dd);
        adv_last = 1'b0;
        if (!reset) begin
            model_clear();
        end else if (p) begin
            for (int i = 0; i < 4; i++) begin
                md[i] = 8'hA5;
                mv[i] = 1'b0;
            end
            sb.delete();
        end else if (e) begin
            for (int i = 3; i > 0; i--) begin
                md[i] = md[i-1];
                mv[i] = mv[i-1];
            end
            md[0] = dd;
            mv[0] = iv;
            if (iv) sb.push_back(dd);
            adv_last = 1'b1;
        end
    endtask

    task automatic check_outputs();
        int t;
        int cnt;
        logic [7:0] exp_d;
        t   = tap_of(dly);
        cnt = 0;
        for (int i = 0; i < 4; i++) cnt += int'(mv[i]);
        check("q", q, md[t-1]);
        check("out_valid", out_valid, mv[t-1]);
        check("occ", occ, cnt);
        // A fresh sample lands on the tap only on an advancing edge.
        if (adv_last && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp_d = sb.pop_front();
                check("sb_data", q, exp_d);
            end
        end
    endtask

    task automatic step(input logic p, input logic e, input logic iv, input logic [7:0] dd);
        preset   = p;
        en       = e;
        in_valid = iv;
        d        = dd;
        @(posedge clk);
        model_edge(p, e, iv, dd);
        #1;
        check_outputs();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        preset   = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        d        = 8'h00;
        dly      = 3'd3;
        model_clear();

        // Reset state before any clock edge
        #1;
        check("rst_q", q, 8'h00);
        check("rst_ov", out_valid, 0);
        check("rst_occ", occ, 0);
        step(1'b0, 1'b1, 1'b1, 8'hC3);
        step(1'b0, 1'b1, 1'b1, 8'hC4);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 1'b1, 8'hFF);

        // Continuous stream at dly=3
        dly = 3'd3;
        step(1'b0, 1'b1, 1'b1, 8'h11);
        step(1'b0, 1'b1, 1'b1, 8'h22);
        step(1'b0, 1'b1, 1'b1, 8'h33);
        check("lat3_q", q, 8'h11);
        check("lat3_ov", out_valid, 1);
        step(1'b0, 1'b1, 1'b1, 8'h44);
        check("occ_full", occ, 4);
        step(1'b0, 1'b1, 1'b1, 8'h55);
        step(1'b0, 1'b1, 1'b1, 8'h66);
        check("occ_hold", occ, 4);

        // Preset from full; every tap shows the pattern
        step(1'b1, 1'b1, 1'b1, 8'h77);
        for (int s = 0; s < 8; s++) begin
            dly = 3'(s);
            #1;
            check("pre_q", q, 8'hA5);
            check("pre_ov", out_valid, 0);
            check("pre_occ", occ, 0);
        end

        // Stall for two cycles after the second sample
        dly = 3'd3;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h11);
        step(1'b0, 1'b1, 1'b1, 8'h22);
        step(1'b0, 1'b0, 1'b1, 8'h99);
        step(1'b0, 1'b0, 1'b1, 8'h98);
        check("stall_occ", occ, 2);
        step(1'b0, 1'b1, 1'b1, 8'h33);
        check("stall_q", q, 8'h11);
        step(1'b0, 1'b1, 1'b1, 8'h44);
        repeat (3) step(1'b0, 1'b1, 1'b0, 8'hEE);
        check("stall_drain", sb.size(), 0);

        // dly=0 acts as dly=1, bubble pattern
        dly = 3'd0;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, (i % 2 == 0), 8'(8'h30 + i));
            check("dly0_q", q, 8'(8'h30 + i));
            check("dly0_ov", out_valid, (i % 2 == 0));
            check("occ_le2", (occ <= 3'd2), 1);
        end

        // dly=7 acts as dly=4
        dly = 3'd7;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, (i % 2 == 0), 8'(8'h40 + i));
            if (i >= 3) begin
                check("dly7_q", q, 8'(8'h40 + i - 3));
                check("dly7_ov", out_valid, ((i - 3) % 2 == 0));
            end
            check("occ_le2", (occ <= 3'd2), 1);
        end

        // Reset pulse mid-stream at dly=4
        dly = 3'd4;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h51);
        step(1'b0, 1'b1, 1'b1, 8'h52);
        step(1'b0, 1'b1, 1'b1, 8'h53);
        step(1'b0, 1'b1, 1'b1, 8'h54);
        check("d4_q", q, 8'h51);
        step(1'b0, 1'b1, 1'b1, 8'h55);
        #2;
        reset = 1'b0;
        #1;
        check("mres_q", q, 8'h00);
        check("mres_ov", out_valid, 0);
        check("mres_occ", occ, 0);
        model_clear();
        #2;
        reset = 1'b1;
        step(1'b0, 1'b1, 1'b1, 8'h61);
        step(1'b0, 1'b1, 1'b1, 8'h62);
        step(1'b0, 1'b1, 1'b1, 8'h63);
        check("refill_ov", out_valid, 0);
        step(1'b0, 1'b1, 1'b1, 8'h64);
        check("refill_q", q, 8'h61);
        check("refill_ov1", out_valid, 1);
        repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00);
        check("refill_drain", sb.size(), 0);

        // Reset released with preset high: preset takes effect at that edge
        reset = 1'b0;
        #1;
        model_clear();
        preset = 1'b1;
        #1;
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("rp_q", q, 8'hA5);
        check("rp_ov", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
